// File: rtl/result_writeback_pkg.sv
// Shared types and constants for the result write-back stage: widths, FSM
// encoding, saturation limits and the lane slicing helper.
package result_writeback_pkg;

   localparam int PARTIAL_SUM_BW = 20;
   localparam int NUM_PE_ROWS    = 8;
   localparam int OUT_BW         = 8;
   localparam int ADDRESSSIZE    = 10;
   localparam int FIFO_DEPTH     = 4;
   localparam int SHIFT_BW       = 5;

   localparam int IN_W   = PARTIAL_SUM_BW * NUM_PE_ROWS;
   localparam int WORD_W = OUT_BW * NUM_PE_ROWS;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   // Limits are held at the widened intermediate width so the clamp compares need no casts.
   localparam logic signed [PARTIAL_SUM_BW:0] SAT_MAX = (PARTIAL_SUM_BW+1)'(2**(OUT_BW-1) - 1);
   localparam logic signed [PARTIAL_SUM_BW:0] SAT_MIN = (PARTIAL_SUM_BW+1)'(-(2**(OUT_BW-1)));

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic logic [PARTIAL_SUM_BW-1:0] lane_slice(input logic [IN_W-1:0] vec,
                                                            input int lane);
      return vec[lane*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
   endfunction

endpackage

// File: rtl/result_writeback_rq_lane.sv
// Combinational requantiser for one lane: optional ReLU, rounding arithmetic
// right shift, then saturation to the signed output width.
module rq_lane
   import result_writeback_pkg::*;
(
   input  logic [PARTIAL_SUM_BW-1:0] x,
   input  logic                      relu_en,
   input  logic [SHIFT_BW-1:0]       shift,
   output logic [OUT_BW-1:0]         y
);

   logic signed [PARTIAL_SUM_BW:0] ext;
   logic signed [PARTIAL_SUM_BW:0] rnd;
   logic signed [PARTIAL_SUM_BW:0] sum;
   logic signed [PARTIAL_SUM_BW:0] r;

   // One extra bit of headroom keeps the rounding add from wrapping at the positive extreme.
   always_comb begin
      ext = {x[PARTIAL_SUM_BW-1], x};
      if (relu_en && x[PARTIAL_SUM_BW-1]) begin
         ext = '0;
      end
      rnd = '0;
      if (shift != '0) begin
         rnd = (PARTIAL_SUM_BW+1)'(1) << (shift - SHIFT_BW'(1));
      end
      sum = ext + rnd;
      r   = sum >>> shift;
      if (r > SAT_MAX) begin
         y = SAT_MAX[OUT_BW-1:0];
      end else if (r < SAT_MIN) begin
         y = SAT_MIN[OUT_BW-1:0];
      end else begin
         y = r[OUT_BW-1:0];
      end
   end

endmodule

// File: rtl/result_writeback.sv
// Requantises multiplier result vectors, packs the lanes into one word and
// writes them to consecutive unified-buffer addresses through a small FIFO.
module result_writeback
   import result_writeback_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [ADDRESSSIZE-1:0] base_addr,
   input  logic [ADDRESSSIZE-1:0] num_rows,
   input  logic                   relu_en,
   input  logic [SHIFT_BW-1:0]    shift,
   input  logic                   in_valid,
   input  logic [IN_W-1:0]        in_data,
   input  logic                   ub_grant,
   output logic                   ub_we,
   output logic [ADDRESSSIZE-1:0] ub_addr,
   output logic [WORD_W-1:0]      ub_wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic                   stray
);

   state_t state, state_next;

   logic [ADDRESSSIZE-1:0] base_q, rows_q, rx_cnt, wr_cnt;
   logic                   relu_q;
   logic [SHIFT_BW-1:0]    shift_q;

   logic [WORD_W-1:0] rq_word, rq_q;
   logic              rq_valid;

   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr;
   logic              fifo_empty, fifo_full, pop, push_ok;
   logic              accept, start_ok;

   for (genvar i = 0; i < NUM_PE_ROWS; i++) begin : g_lane
      rq_lane u_rq (
         .x       (lane_slice(in_data, i)),
         .relu_en (relu_q),
         .shift   (shift_q),
         .y       (rq_word[i*OUT_BW +: OUT_BW])
      );
   end

   // The extra pointer bit tells a full FIFO apart from an empty one.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop        = !fifo_empty && ub_grant;
   assign push_ok    = rq_valid && (!fifo_full || pop);
   assign accept     = (state == ST_ACTIVE) && in_valid;
   assign start_ok   = (state == ST_IDLE) && start;

   assign ub_we    = pop;
   assign ub_addr  = base_q + wr_cnt;
   assign ub_wdata = mem[rd_ptr[PTR_W-1:0]];
   assign busy     = (state == ST_ACTIVE) || (state == ST_DRAIN);

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = (num_rows == '0) ? ST_DONE : ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (in_valid && (rx_cnt + ADDRESSSIZE'(1) == rows_q)) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!rq_valid && fifo_empty) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         base_q   <= '0;
         rows_q   <= '0;
         relu_q   <= 1'b0;
         shift_q  <= '0;
         rx_cnt   <= '0;
         wr_cnt   <= '0;
         rq_q     <= '0;
         rq_valid <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         stray    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         state    <= state_next;
         done     <= (state == ST_DONE);
         rq_valid <= accept;
         if (accept) begin
            rq_q   <= rq_word;
            rx_cnt <= rx_cnt + ADDRESSSIZE'(1);
         end
         if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= rq_q;
            wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
         end
         if (rq_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            wr_cnt <= wr_cnt + ADDRESSSIZE'(1);
         end
         if (start_ok) begin
            base_q   <= base_addr;
            rows_q   <= num_rows;
            relu_q   <= relu_en;
            shift_q  <= shift;
            rx_cnt   <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
            stray    <= 1'b0;
         end
         // A stray vector in the same cycle as start still marks the new job.
         if (in_valid && state != ST_ACTIVE) begin
            stray <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: a transaction-level model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_result_writeback;
   import result_writeback_pkg::*;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   start = 1'b0;
   logic [ADDRESSSIZE-1:0] base_addr = '0;
   logic [ADDRESSSIZE-1:0] num_rows = '0;
   logic                   relu_en = 1'b0;
   logic [SHIFT_BW-1:0]    shift = '0;
   logic                   in_valid = 1'b0;
   logic [IN_W-1:0]        in_data = '0;
   logic                   ub_grant = 1'b0;
   logic                   ub_we;
   logic [ADDRESSSIZE-1:0] ub_addr;
   logic [WORD_W-1:0]      ub_wdata;
   logic                   busy, done, overflow, stray;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   result_writeback dut (
      .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
      .num_rows(num_rows), .relu_en(relu_en), .shift(shift),
      .in_valid(in_valid), .in_data(in_data), .ub_grant(ub_grant),
      .ub_we(ub_we), .ub_addr(ub_addr), .ub_wdata(ub_wdata),
      .busy(busy), .done(done), .overflow(overflow), .stray(stray)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference arithmetic straight from the requantisation rules.
   function automatic logic [OUT_BW-1:0] rq_model(input int x, input bit relu, input int sh);
      int v, r;
      logic [31:0] rb;
      v = (relu && x < 0) ? 0 : x;
      r = (sh > 0) ? ((v + (1 << (sh - 1))) >>> sh) : v;
      if (r > (1 << (OUT_BW - 1)) - 1) r = (1 << (OUT_BW - 1)) - 1;
      if (r < -(1 << (OUT_BW - 1))) r = -(1 << (OUT_BW - 1));
      rb = r;
      return rb[OUT_BW-1:0];
   endfunction

   function automatic logic [WORD_W-1:0] model_word(input logic [IN_W-1:0] d, input bit relu, input int sh);
      logic [WORD_W-1:0] w;
      logic signed [PARTIAL_SUM_BW-1:0] lane;
      w = '0;
      for (int i = 0; i < NUM_PE_ROWS; i++) begin
         lane = d[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
         w[i*OUT_BW +: OUT_BW] = rq_model(int'(lane), relu, sh);
      end
      return w;
   endfunction

   function automatic logic [IN_W-1:0] pack(input int a, b, c, d, e, f, g, h);
      int l[8];
      logic [IN_W-1:0] v;
      l = '{a, b, c, d, e, f, g, h};
      v = '0;
      for (int i = 0; i < NUM_PE_ROWS; i++) v[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = PARTIAL_SUM_BW'(l[i]);
      return v;
   endfunction

   typedef enum {M_IDLE, M_COLLECT, M_DRAIN, M_FINISH} mphase_t;
   mphase_t           ph = M_IDLE;
   logic [WORD_W-1:0] fq[$];
   bit                stage_v = 0;
   logic [WORD_W-1:0] stage_w = '0;
   int                remaining = 0, m_base = 0, m_wr = 0, m_shift = 0;
   bit                m_relu = 0, m_ovf = 0, m_stray = 0, m_done = 0;

   int                log_addr[$];
   logic [63:0]       log_data[$];
   int                first_we_cyc = -1;

   // Compare process: check outputs against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      bit exp_we, drain_exit;
      mphase_t old_ph;
      if (!rstn) begin
         ph = M_IDLE; fq.delete(); stage_v = 0; remaining = 0; m_base = 0; m_wr = 0;
         m_ovf = 0; m_stray = 0; m_done = 0;
         check_output("rst ub_we", 64'(ub_we), 64'd0);
         check_output("rst ub_addr", 64'(ub_addr), 64'd0);
         check_output("rst ub_wdata", 64'(ub_wdata), 64'd0);
         check_output("rst flags", {60'd0, busy, done, overflow, stray}, 64'd0);
      end else begin
         exp_we = (fq.size() > 0) && ub_grant;
         check_output("ub_we", 64'(ub_we), 64'(exp_we));
         check_output("ub_addr", 64'(ub_addr), 64'((m_base + m_wr) % (1 << ADDRESSSIZE)));
         if (exp_we) check_output("ub_wdata", 64'(ub_wdata), 64'(fq[0]));
         check_output("busy", 64'(busy), 64'(ph == M_COLLECT || ph == M_DRAIN));
         check_output("done", 64'(done), 64'(m_done));
         check_output("overflow", 64'(overflow), 64'(m_ovf));
         check_output("stray", 64'(stray), 64'(m_stray));
         if (ub_we) begin
            log_addr.push_back(int'(ub_addr));
            log_data.push_back(64'(ub_wdata));
            if (first_we_cyc < 0) first_we_cyc = cyc;
         end
         drain_exit = !stage_v && fq.size() == 0;
         old_ph = ph;
         if (exp_we) begin void'(fq.pop_front()); m_wr++; end
         if (stage_v) begin
            if (fq.size() < FIFO_DEPTH) fq.push_back(stage_w);
            else m_ovf = 1;
         end
         stage_v = 0;
         m_done = (ph == M_FINISH);
         case (ph)
            M_IDLE: if (start) begin
               m_base = int'(base_addr); m_wr = 0; m_relu = relu_en; m_shift = int'(shift);
               remaining = int'(num_rows); m_ovf = 0; m_stray = 0;
               ph = (num_rows == '0) ? M_FINISH : M_COLLECT;
            end
            M_COLLECT: if (in_valid) begin
               stage_v = 1; stage_w = model_word(in_data, m_relu, m_shift);
               remaining--;
               if (remaining == 0) ph = M_DRAIN;
            end
            M_DRAIN: if (drain_exit) ph = M_FINISH;
            default: ph = M_IDLE;
         endcase
         if (in_valid && old_ph != M_COLLECT) m_stray = 1;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_log();
      log_addr.delete(); log_data.delete(); first_we_cyc = -1;
   endtask

   task automatic start_job(input int base, input int rows, input bit relu, input int sh);
      start = 1'b1; base_addr = ADDRESSSIZE'(base); num_rows = ADDRESSSIZE'(rows);
      relu_en = relu; shift = SHIFT_BW'(sh);
      tick();
      start = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [IN_W-1:0] vec);
      in_valid = 1'b1; in_data = vec;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin tick(); n++; end
      check_output({name, " done"}, 64'(done), 64'd1);
      tick();
   endtask

   initial begin
      int k;
      logic [IN_W-1:0] v;

      check_output("model 100>>4", 64'(rq_model(100, 0, 4)), 64'h06);
      check_output("model -100>>4", 64'(rq_model(-100, 0, 4)), 64'hFA);
      check_output("model relu -5", 64'(rq_model(-5, 1, 1)), 64'h00);
      check_output("model 255>>1", 64'(rq_model(255, 1, 1)), 64'h7F);

      repeat (3) tick();
      check_output("reset busy/done/ovf/stray", {60'd0, busy, done, overflow, stray}, 64'd0);
      check_output("reset ub_addr", 64'(ub_addr), 64'd0);
      check_output("reset ub_wdata", 64'(ub_wdata), 64'd0);
      rstn = 1'b1;
      tick();

      // Basic requantisation and k+2 latency.
      ub_grant = 1'b1; clear_log();
      start_job(10'h010, 3, 0, 4);
      v = pack(100, -100, 40000, -40000, 0, 16, -8, 8);
      k = cyc;
      apply_stimulus(v); apply_stimulus(v); apply_stimulus(v);
      wait_done("basic", 20);
      check_output("basic writes", 64'(log_addr.size()), 64'd3);
      if (log_addr.size() == 3) begin
         check_output("basic word", log_data[0], 64'h01000100_807FFA06);
         check_output("basic addr0", 64'(log_addr[0]), 64'h010);
         check_output("basic addr2", 64'(log_addr[2]), 64'h012);
      end
      check_output("basic latency", 64'(first_we_cyc - k), 64'd2);

      // ReLU with rounding.
      clear_log();
      start_job(10'h040, 1, 1, 1);
      apply_stimulus(pack(-5, 3, 0, 255, 0, 0, 0, 0));
      wait_done("relu", 20);
      check_output("relu writes", 64'(log_addr.size()), 64'd1);
      if (log_addr.size() == 1) check_output("relu word", log_data[0], 64'h00000000_7F000200);

      // Backpressure: fill the FIFO, then overflow it.
      ub_grant = 1'b0; clear_log();
      start_job(10'h100, 5, 0, 0);
      for (int j = 1; j <= 4; j++) apply_stimulus(pack(j, j, j, j, j, j, j, j));
      tick(); tick();
      check_output("bp no overflow", 64'(overflow), 64'd0);
      apply_stimulus(pack(5, 5, 5, 5, 5, 5, 5, 5));
      tick(); tick();
      check_output("bp overflow", 64'(overflow), 64'd1);
      check_output("bp no writes yet", 64'(log_addr.size()), 64'd0);
      ub_grant = 1'b1;
      wait_done("bp", 30);
      check_output("bp writes", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) check_output("bp last word", log_data[3], 64'h04040404_04040404);
      check_output("bp overflow sticky", 64'(overflow), 64'd1);

      // Address wrap.
      clear_log();
      start_job(10'h3FE, 4, 0, 0);
      for (int j = 0; j < 4; j++) apply_stimulus(pack(j, 0, 0, 0, 0, 0, 0, 0));
      wait_done("wrap", 20);
      check_output("wrap writes", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) begin
         check_output("wrap addr1", 64'(log_addr[1]), 64'h3FF);
         check_output("wrap addr2", 64'(log_addr[2]), 64'h000);
         check_output("wrap addr3", 64'(log_addr[3]), 64'h001);
      end

      // num_rows == 0.
      clear_log();
      start_job(10'h055, 0, 0, 0);
      check_output("zero rows done early", 64'(done), 64'd0);
      tick();
      check_output("zero rows done", 64'(done), 64'd1);
      tick();
      check_output("zero rows done once", 64'(done), 64'd0);
      check_output("zero rows no write", 64'(log_addr.size()), 64'd0);

      // start while busy is ignored.
      clear_log();
      start_job(10'h020, 2, 0, 0);
      apply_stimulus(pack(7, 0, 0, 0, 0, 0, 0, 0));
      start_job(10'h200, 7, 1, 3);
      apply_stimulus(pack(9, 0, 0, 0, 0, 0, 0, 0));
      wait_done("restart", 20);
      check_output("restart writes", 64'(log_addr.size()), 64'd2);
      if (log_addr.size() == 2) begin
         check_output("restart addr1", 64'(log_addr[1]), 64'h021);
         check_output("restart word1", log_data[1], 64'h9);
      end

      // Stray vector while idle.
      clear_log();
      apply_stimulus(pack(1, 1, 1, 1, 1, 1, 1, 1));
      tick();
      check_output("stray set", 64'(stray), 64'd1);
      check_output("stray no write", 64'(log_addr.size()), 64'd0);
      start_job(10'h030, 1, 0, 0);
      check_output("stray cleared", 64'(stray), 64'd0);
      apply_stimulus(pack(2, 0, 0, 0, 0, 0, 0, 0));
      wait_done("stray job", 20);

      // Reset mid-job, then a clean job.
      start_job(10'h080, 5, 0, 0);
      apply_stimulus(pack(3, 0, 0, 0, 0, 0, 0, 0));
      apply_stimulus(pack(4, 0, 0, 0, 0, 0, 0, 0));
      rstn = 1'b0;
      #1;
      check_output("midrst ub_we", 64'(ub_we), 64'd0);
      check_output("midrst ub_addr", 64'(ub_addr), 64'd0);
      check_output("midrst flags", {60'd0, busy, done, overflow, stray}, 64'd0);
      tick(); tick();
      rstn = 1'b1;
      tick();
      clear_log();
      start_job(10'h0C0, 2, 0, 2);
      apply_stimulus(pack(10, -10, 6, -6, 0, 0, 0, 0));
      apply_stimulus(pack(0, 0, 0, 0, 0, 0, 0, 0));
      wait_done("post reset", 20);
      check_output("post reset writes", 64'(log_addr.size()), 64'd2);
      if (log_addr.size() == 2) begin
         check_output("post reset addr0", 64'(log_addr[0]), 64'h0C0);
         check_output("post reset word0", log_data[0], 64'h00000000_FF02FE03);
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Sits directly downstream of the 8-lane vector multiplier.
- Per lane, it takes the signed partial-sum result vector, applies optional ReLU, a rounding right shift and saturation to 8 bits.
- It packs the 8 lanes into one 64-bit word and writes that word back into the unified buffer at consecutive addresses, so the next layer can use it as input.
- A small FIFO absorbs cycles in which the unified-buffer write port is not granted.

Parameters:
- PARTIAL_SUM_BW, 20: width of each signed lane result from the multiplier.
- NUM_PE_ROWS, 8: number of lanes per result vector.
- OUT_BW, 8: signed width of each requantised lane.
- ADDRESSSIZE, 10: unified-buffer address width.
- FIFO_DEPTH, 4: number of entries in the write-back FIFO; must be a power of 2.
- SHIFT_BW, 5: width of the shift-amount input.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a job; ignored unless the block is IDLE.
- base_addr  in  ADDRESSSIZE  first write address; latched on start.
- num_rows  in  ADDRESSSIZE  number of result vectors expected; latched on start.
- relu_en  in  1  enables ReLU; latched on start.
- shift  in  SHIFT_BW  right-shift amount, 0..PARTIAL_SUM_BW-1; latched on start.
- in_valid  in  1  result vector valid this cycle (no backpressure).
- in_data  in  PARTIAL_SUM_BW*NUM_PE_ROWS  result vector; lane i is at bits [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
- ub_grant  in  1  unified-buffer write port is available this cycle.
- ub_we  out  1  write strobe.
- ub_addr  out  ADDRESSSIZE  write address.
- ub_wdata  out  OUT_BW*NUM_PE_ROWS  packed output word; lane i is at bits [i*OUT_BW +: OUT_BW].
- busy  out  1  high while the block is in ACTIVE or DRAIN.
- done  out  1  one-cycle pulse when the job completes.
- overflow  out  1  sticky flag: a vector was dropped because the FIFO was full.
- stray  out  1  sticky flag: in_valid arrived while the block was IDLE.

Behaviour:
- Reset (asynchronous, rstn low) clears all state:
  - FSM goes to IDLE.
  - ub_we, done, busy, overflow and stray are 0.
  - ub_addr and ub_wdata are 0.
  - FIFO is empty; all counters are 0.
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE: on start, latch the configuration inputs, clear overflow and stray, reset rx_cnt and wr_cnt, go to ACTIVE. If num_rows==0, go to DONE instead.
  - ACTIVE: each in_valid increments rx_cnt. When rx_cnt reaches num_rows, go to DRAIN.
  - DRAIN: wait until the requant stage and the FIFO are both empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- in_valid outside ACTIVE (IDLE, DRAIN or DONE): the vector is discarded and stray is set.
- Requantisation, per lane, registered as one pipeline stage:
  - x = signed lane value.
  - If relu_en and x<0, x = 0.
  - If shift>0, r = (x + 2^(shift-1)) >>> shift; otherwise r = x. Use PARTIAL_SUM_BW+1-bit intermediate arithmetic so the rounding add cannot overflow.
  - Saturate r to [-2^(OUT_BW-1), 2^(OUT_BW-1)-1].
- FIFO:
  - The requant register pushes into the FIFO one cycle after capture.
  - If the FIFO is full on a push, that vector is dropped and overflow is set. The dropped vector still counts toward rx_cnt.
  - A push and a pop in the same cycle are permitted, including when the FIFO is full: the pop frees the slot first.
- Write side:
  - ub_we = FIFO not empty AND ub_grant (combinational from registered state).
  - ub_addr = base_addr + wr_cnt, wrapping modulo 2^ADDRESSSIZE.
  - ub_wdata = FIFO head.
  - Each ub_we cycle pops the FIFO and increments wr_cnt.
- Latency: in_valid in cycle k, with ub_grant held high and the FIFO empty, gives ub_we in cycle k+2.
- start while busy is ignored and leaves all state unchanged.
- Reset mid-job aborts the job with no done pulse; the FIFO contents are lost.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit typedef).
  - Saturation limit constants derived from OUT_BW.
  - The lane-slice helper.
- One natural sub-module: rq_lane, a combinational ReLU/round/shift/saturate unit for a single lane, instantiated NUM_PE_ROWS times.
- The FIFO is built inline; pointers carry an extra wrap bit so full and empty can be distinguished.

Test Plan:
- Basic requantisation, shift=4, relu_en=0, base_addr=0x010, num_rows=3, ub_grant=1. Lane values 100, -100, 40000 and -40000 must give 6, -6, 127 and -128 (100/16=6.25 rounds to 6; -100/16=-6.25 rounds to -6). Three writes at addresses 0x010..0x012, the first in cycle k+2, then one done pulse.
- ReLU and rounding, relu_en=1, shift=1. Lanes -5, 3, 0, 255 must give 0, 2, 0, 127.
- Backpressure, ub_grant=0 while 4 vectors arrive, then grant opens. Expect 4 writes with no overflow. A 5th back-to-back vector while the FIFO is full and grant is still 0 must set overflow; rx_cnt still reaches num_rows and done still fires.
- Address wrap, base_addr=0x3FE, num_rows=4. Writes must go to 0x3FE, 0x3FF, 0x000, 0x001.
- Edge cases:
  - num_rows=0: done pulses two cycles after start, with no ub_we.
  - start during ACTIVE: ignored.
  - in_valid while IDLE: sets stray, with no write.
- Reset mid-job: pull rstn low after 2 of 5 vectors. All outputs must go to 0 immediately and the FSM to IDLE; a new start must then run cleanly.
